// File: rtl/mips_pkg.sv
// Shared datapath definitions: word/register widths, typed select sources and
// the state encoding of the output skid buffer used by mux_pipe_stage.
package mips_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_src_t;

    typedef enum logic [0:0] {
        ALU_SRC_REG = 1'b0,
        ALU_SRC_IMM = 1'b1
    } alu_src_t;

    typedef enum logic [0:0] {
        REG_DST_RT = 1'b0,
        REG_DST_RD = 1'b1
    } reg_dst_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: main output register plus one overflow entry, with a
// registered in_ready so downstream stalls never reach upstream combinationally.
module skid_buffer
    import mips_pkg::*;
#(
    parameter int P_W = 34
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           flush,
    input  logic [P_W-1:0] in_payload,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [P_W-1:0] out_payload,
    output logic           out_valid,
    input  logic           out_ready
);

    skid_state_t    state_r, state_s;
    logic [P_W-1:0] main_r, main_s;
    logic [P_W-1:0] skid_r, skid_s;
    logic           in_ready_r;
    logic           out_valid_r;
    logic           accept_s;
    logic           emit_s;

    assign accept_s = in_valid & in_ready_r;
    assign emit_s   = out_valid_r & out_ready;

    // Next-state and storage-load decisions; flush overrides every transition.
    always_comb begin
        state_s = state_r;
        main_s  = main_r;
        skid_s  = skid_r;
        if (flush) begin
            state_s = SKID_EMPTY;
        end else begin
            case (state_r)
                SKID_EMPTY: begin
                    if (accept_s) begin
                        state_s = SKID_ONE;
                        main_s  = in_payload;
                    end else begin
                        state_s = SKID_EMPTY;
                    end
                end
                SKID_ONE: begin
                    if (accept_s && emit_s) begin
                        main_s = in_payload;
                    end else if (accept_s) begin
                        state_s = SKID_FULL;
                        skid_s  = in_payload;
                    end else if (emit_s) begin
                        state_s = SKID_EMPTY;
                    end else begin
                        state_s = SKID_ONE;
                    end
                end
                SKID_FULL: begin
                    if (emit_s) begin
                        state_s = SKID_ONE;
                        main_s  = skid_r;
                    end else begin
                        state_s = SKID_FULL;
                    end
                end
                default: begin
                    state_s = SKID_EMPTY;
                end
            endcase
        end
    end

    // State, storage and registered handshake outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= SKID_EMPTY;
            main_r      <= {P_W{1'b0}};
            skid_r      <= {P_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            main_r      <= main_s;
            skid_r      <= skid_s;
            in_ready_r  <= (state_s != SKID_FULL);
            out_valid_r <= (state_s != SKID_EMPTY);
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_payload = main_r;

endmodule

// File: rtl/mux_pipe_stage.sv
// N-input registered select stage with valid/ready handshake and sticky select
// error. Define MUX_PIPE_PERF_EN to add the beat_count/stall_count outputs.
module mux_pipe_stage
    import mips_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_sel,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sel_err
`ifdef MUX_PIPE_PERF_EN
    ,
    output logic [15:0]                 beat_count,
    output logic [15:0]                 stall_count
`endif
);

    localparam int P_W = WIDTH + SEL_W;

    logic [WIDTH-1:0] sel_data_s;
    logic             sel_hit_s;
    logic [P_W-1:0]   out_payload_s;
    logic             sel_err_r;

    // AND-OR select; codes with no matching input leave data at zero and hit low.
    always_comb begin
        sel_data_s = {WIDTH{1'b0}};
        sel_hit_s  = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            sel_hit_s  = sel_hit_s | (in_sel == SEL_W'(k));
            sel_data_s = sel_data_s |
                         ({WIDTH{in_sel == SEL_W'(k)}} & in_data[k*WIDTH +: WIDTH]);
        end
    end

    skid_buffer #(
        .P_W (P_W)
    ) u_skid (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_payload  ({sel_data_s, in_sel}),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_payload (out_payload_s),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    assign out_data = out_payload_s[P_W-1:SEL_W];
    assign out_sel  = out_payload_s[SEL_W-1:0];

    // Sticky error, raised only by an accepted out-of-range select.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_err_r <= 1'b0;
        end else if (flush) begin
            sel_err_r <= 1'b0;
        end else if (in_valid && in_ready && !sel_hit_s) begin
            sel_err_r <= 1'b1;
        end else begin
            sel_err_r <= sel_err_r;
        end
    end

    assign sel_err = sel_err_r;

`ifdef MUX_PIPE_PERF_EN
    logic [15:0] beat_count_r;
    logic [15:0] stall_count_r;

    // Emit counter wraps; stall counter saturates; neither is touched by flush.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat_count_r  <= 16'd0;
            stall_count_r <= 16'd0;
        end else begin
            if (out_valid && out_ready) begin
                beat_count_r <= beat_count_r + 16'd1;
            end else begin
                beat_count_r <= beat_count_r;
            end
            if (out_valid && !out_ready && (stall_count_r != 16'hFFFF)) begin
                stall_count_r <= stall_count_r + 16'd1;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign beat_count  = beat_count_r;
    assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Self-checking bench for mux_pipe_stage: directed steps on a 4-input and a
// 3-input instance, then a randomized run against a queue reference model.
module tb_mux_pipe_stage;

    localparam int AW = 32;
    localparam int BW = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;

    logic [4*AW-1:0] a_in_data;
    logic [1:0]      a_in_sel;
    logic            a_in_valid, a_in_ready, a_flush;
    logic [AW-1:0]   a_out_data;
    logic [1:0]      a_out_sel;
    logic            a_out_valid, a_out_ready, a_sel_err;

    logic [3*BW-1:0] b_in_data;
    logic [1:0]      b_in_sel;
    logic            b_in_valid, b_in_ready, b_flush;
    logic [BW-1:0]   b_out_data;
    logic [1:0]      b_out_sel;
    logic            b_out_valid, b_out_ready, b_sel_err;

`ifdef MUX_PIPE_PERF_EN
    logic [15:0] a_beat_count, a_stall_count, b_beat_count, b_stall_count;
`endif

    mux_pipe_stage #(.WIDTH(AW), .NUM_INPUTS(4)) u_a (
        .clock(clock), .reset_n(reset_n), .in_data(a_in_data), .in_sel(a_in_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(a_flush),
        .out_data(a_out_data), .out_sel(a_out_sel), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .sel_err(a_sel_err)
`ifdef MUX_PIPE_PERF_EN
        , .beat_count(a_beat_count), .stall_count(a_stall_count)
`endif
    );

    mux_pipe_stage #(.WIDTH(BW), .NUM_INPUTS(3)) u_b (
        .clock(clock), .reset_n(reset_n), .in_data(b_in_data), .in_sel(b_in_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
        .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .sel_err(b_sel_err)
`ifdef MUX_PIPE_PERF_EN
        , .beat_count(b_beat_count), .stall_count(b_stall_count)
`endif
    );

    typedef struct {
        logic [BW-1:0] d;
        logic [1:0]    s;
    } beat_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        beat_t       q[$];
        beat_t       nb;
        logic        m_err;
        logic        acc, em;
        int          sel;

        reset_n     = 1'b0;
        a_in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        a_in_sel    = 2'd0;
        a_in_valid  = 1'b0;
        a_flush     = 1'b0;
        a_out_ready = 1'b0;
        b_in_data   = {16'hB2, 16'hB1, 16'hB0};
        b_in_sel    = 2'd0;
        b_in_valid  = 1'b0;
        b_flush     = 1'b0;
        b_out_ready = 1'b0;
        step();
        step();
        chk("rst_data", a_out_data, 32'h0);
        chk("rst_sel", a_out_sel, 2'd0);
        chk("rst_valid", a_out_valid, 1'b0);
        chk("rst_ready", a_in_ready, 1'b1);
        chk("rst_err", a_sel_err, 1'b0);
        reset_n = 1'b1;

        // Single beat, select 2
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_sel    = 2'd2;
        step();
        a_in_valid = 1'b0;
        chk("t1_data", a_out_data, 32'hA2);
        chk("t1_sel", a_out_sel, 2'd2);
        chk("t1_valid", a_out_valid, 1'b1);
        step();
        chk("t1_drain", a_out_valid, 1'b0);

        // Stream with downstream stalled after the first beat
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_sel    = 2'd0;
        step();
        chk("s_ready_one", a_in_ready, 1'b1);
        chk("s_d0", a_out_data, 32'hA0);
        a_in_sel = 2'd1;
        step();
        chk("s_ready_full", a_in_ready, 1'b0);
        chk("s_hold0", a_out_data, 32'hA0);
        a_in_sel = 2'd2;
        step();
        chk("s_stall_ready", a_in_ready, 1'b0);
        chk("s_stable_data", a_out_data, 32'hA0);
        chk("s_stable_sel", a_out_sel, 2'd0);
        a_out_ready = 1'b1;
        step();
        chk("s_d1", a_out_data, 32'hA1);
        chk("s_d1_ready", a_in_ready, 1'b1);
        step();
        chk("s_d2", a_out_data, 32'hA2);
        a_in_sel = 2'd3;
        step();
        chk("s_d3", a_out_data, 32'hA3);
        chk("s_d3_valid", a_out_valid, 1'b1);
        a_in_valid = 1'b0;
        step();
        chk("s_empty", a_out_valid, 1'b0);

        // Out-of-range select offered while FULL must not set the error
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_sel    = 2'd0;
        step();
        b_in_sel = 2'd1;
        step();
        b_in_sel = 2'd3;
        step();
        chk("b_full_ready", b_in_ready, 1'b0);
        chk("b_unacc_err", b_sel_err, 1'b0);
        chk("b_full_data", b_out_data, 16'hB0);

        // Flush while FULL with a beat presented
        b_flush  = 1'b1;
        b_in_sel = 2'd2;
        step();
        b_flush    = 1'b0;
        b_in_valid = 1'b0;
        chk("fl_valid", b_out_valid, 1'b0);
        chk("fl_ready", b_in_ready, 1'b1);
        b_out_ready = 1'b1;
        step();
        chk("fl_absent", b_out_valid, 1'b0);

        // Out-of-range select accepted, sticky, cleared by flush
        b_in_valid = 1'b1;
        b_in_sel   = 2'd3;
        step();
        chk("oor_data", b_out_data, 16'h0);
        chk("oor_sel", b_out_sel, 2'd3);
        chk("oor_err", b_sel_err, 1'b1);
        b_in_sel = 2'd0;
        step();
        b_in_valid = 1'b0;
        chk("oor_next_data", b_out_data, 16'hB0);
        chk("oor_sticky", b_sel_err, 1'b1);
        b_flush = 1'b1;
        step();
        b_flush = 1'b0;
        chk("oor_flushed", b_sel_err, 1'b0);

        // Asynchronous reset between edges while FULL
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_sel    = 2'd1;
        step();
        a_in_sel = 2'd2;
        step();
        a_in_valid = 1'b0;
        chk("ar_pre_ready", a_in_ready, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", a_out_valid, 1'b0);
        chk("ar_ready", a_in_ready, 1'b1);
        chk("ar_data", a_out_data, 32'h0);
        chk("ar_sel", a_out_sel, 2'd0);
        #1;
        reset_n = 1'b1;
        step();

        // Randomized run on the 3-input instance against a FIFO model
        b_flush    = 1'b0;
        b_in_valid = 1'b0;
        q.delete();
        m_err = 1'b0;
        for (int i = 0; i < 400; i++) begin
            chk("r_valid", b_out_valid, q.size() > 0);
            chk("r_ready", b_in_ready, q.size() < 2);
            chk("r_err", b_sel_err, m_err);
            if (q.size() > 0) begin
                chk("r_data", b_out_data, q[0].d);
                chk("r_sel", b_out_sel, q[0].s);
            end
            for (int k = 0; k < 3; k++) begin
                b_in_data[k*BW +: BW] = 16'($urandom());
            end
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_sel    = 2'($urandom_range(0, 3));
            b_out_ready = 1'($urandom_range(0, 1));
            b_flush     = ($urandom_range(0, 15) == 0);
            sel = int'(b_in_sel);
            acc = b_in_valid && (q.size() < 2);
            em  = (q.size() > 0) && b_out_ready;
            if (b_flush) begin
                q.delete();
                m_err = 1'b0;
            end else begin
                if (em) begin
                    void'(q.pop_front());
                end
                if (acc) begin
                    nb.s = b_in_sel;
                    nb.d = (sel < 3) ? b_in_data[sel*BW +: BW] : 16'h0;
                    q.push_back(nb);
                    if (sel >= 3) begin
                        m_err = 1'b1;
                    end
                end
            end
            step();
        end
        b_in_valid = 1'b0;
        b_flush    = 1'b0;

`ifdef MUX_PIPE_PERF_EN
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("pc_rst_beats", a_beat_count, 16'd0);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_sel    = 2'd0;
        step();
        a_in_valid = 1'b0;
        repeat (3) step();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        repeat (70000) step();
        a_in_valid = 1'b0;
        chk("pc_beats", a_beat_count, 16'd4464);
        chk("pc_stalls", a_stall_count, 16'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
